// File: rtl/player_interact.sv
// rtl/player_interact.sv - pick-up / put-down / chop controller for the object in front of the player
module player_interact #(
  parameter int CHOP_CYCLES = 97_500_000,
  parameter int CNT_W       = 27
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [3:0]       object_in,
  input  logic [3:0]       front_x_in,
  input  logic [2:0]       front_y_in,
  input  logic             front_valid_in,
  input  logic             grab_in,
  input  logic             chop_in,
  output logic [3:0]       held_out,
  output logic             wr_en_out,
  output logic [3:0]       wr_x_out,
  output logic [2:0]       wr_y_out,
  output logic [3:0]       wr_obj_out,
  output logic [CNT_W-1:0] chop_progress_out,
  output logic             chopping_out,
  output logic             chop_done_out
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHOP   = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  localparam logic [3:0] OBJ_EMPTY = 4'd0;
  localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'(CHOP_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       held_q, held_d;
  logic             wr_en_q, wr_en_d;
  logic [3:0]       wr_x_q, wr_x_d;
  logic [2:0]       wr_y_q, wr_y_d;
  logic [3:0]       wr_obj_q, wr_obj_d;
  logic [CNT_W-1:0] progress_q, progress_d;
  logic             chop_done_q, chop_done_d;
  logic             grab_prev_q, grab_prev_d;
  logic [3:0]       lat_obj_q, lat_obj_d;
  logic [3:0]       lat_x_q, lat_x_d;
  logic [2:0]       lat_y_q, lat_y_d;

  logic grab_evt;
  logic chop_abort;

  function automatic logic is_pickable(input logic [3:0] obj);
    return (obj >= 4'd2) && (obj <= 4'd6);
  endfunction

  function automatic logic is_choppable(input logic [3:0] obj);
    return (obj == 4'd2) || (obj == 4'd4);
  endfunction

  assign grab_evt   = grab_in & ~grab_prev_q;
  assign chop_abort = !chop_in || !front_valid_in || (front_x_in != lat_x_q) ||
                      (front_y_in != lat_y_q) || (object_in != lat_obj_q);

  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    wr_en_d     = 1'b0;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    wr_obj_d    = wr_obj_q;
    progress_d  = progress_q;
    chop_done_d = 1'b0;
    grab_prev_d = grab_in;
    lat_obj_d   = lat_obj_q;
    lat_x_d     = lat_x_q;
    lat_y_d     = lat_y_q;

    case (state_q)
      ST_IDLE: begin
        progress_d = '0;
        if (front_valid_in) begin
          // A grab edge always takes priority over starting a chop.
          if (grab_evt) begin
            if (held_q == OBJ_EMPTY && is_pickable(object_in)) begin
              wr_en_d  = 1'b1;
              wr_x_d   = front_x_in;
              wr_y_d   = front_y_in;
              wr_obj_d = OBJ_EMPTY;
              held_d   = object_in;
              state_d  = ST_WRITE;
            end else if (held_q != OBJ_EMPTY && object_in == OBJ_EMPTY) begin
              wr_en_d  = 1'b1;
              wr_x_d   = front_x_in;
              wr_y_d   = front_y_in;
              wr_obj_d = held_q;
              held_d   = OBJ_EMPTY;
              state_d  = ST_WRITE;
            end
          end else if (chop_in && held_q == OBJ_EMPTY && is_choppable(object_in)) begin
            lat_obj_d = object_in;
            lat_x_d   = front_x_in;
            lat_y_d   = front_y_in;
            state_d   = ST_CHOP;
          end
        end
      end
      ST_CHOP: begin
        if (chop_abort) begin
          progress_d = '0;
          state_d    = ST_IDLE;
        end else if (progress_q == PROG_LAST) begin
          wr_en_d     = 1'b1;
          wr_x_d      = lat_x_q;
          wr_y_d      = lat_y_q;
          wr_obj_d    = lat_obj_q + 4'd1;
          chop_done_d = 1'b1;
          progress_d  = '0;
          state_d     = ST_WRITE;
        end else begin
          progress_d = progress_q + 1'b1;
        end
      end
      ST_WRITE:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      held_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_obj_q    <= '0;
      progress_q  <= '0;
      chop_done_q <= 1'b0;
      // Loaded high so a button held through reset does not register as an edge.
      grab_prev_q <= 1'b1;
      lat_obj_q   <= '0;
      lat_x_q     <= '0;
      lat_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      wr_en_q     <= wr_en_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      wr_obj_q    <= wr_obj_d;
      progress_q  <= progress_d;
      chop_done_q <= chop_done_d;
      grab_prev_q <= grab_prev_d;
      lat_obj_q   <= lat_obj_d;
      lat_x_q     <= lat_x_d;
      lat_y_q     <= lat_y_d;
    end
  end

  assign held_out          = held_q;
  assign wr_en_out         = wr_en_q;
  assign wr_x_out          = wr_x_q;
  assign wr_y_out          = wr_y_q;
  assign wr_obj_out        = wr_obj_q;
  assign chop_progress_out = progress_q;
  assign chopping_out      = (state_q == ST_CHOP);
  assign chop_done_out     = chop_done_q;

endmodule

// File: tb/tb_player_interact.sv
// tb/tb_player_interact.sv - directed self-checking bench for player_interact
module tb_player_interact;

  localparam int CNT_W = 27;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic [3:0]       object_in;
  logic [3:0]       front_x_in;
  logic [2:0]       front_y_in;
  logic             front_valid_in;
  logic             grab_in;
  logic             chop_in;
  logic [3:0]       held_out;
  logic             wr_en_out;
  logic [3:0]       wr_x_out;
  logic [2:0]       wr_y_out;
  logic [3:0]       wr_obj_out;
  logic [CNT_W-1:0] chop_progress_out;
  logic             chopping_out;
  logic             chop_done_out;

  int total = 0;
  int bad   = 0;
  int writes;

  player_interact #(.CHOP_CYCLES(8), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .object_in(object_in),
    .front_x_in(front_x_in), .front_y_in(front_y_in), .front_valid_in(front_valid_in),
    .grab_in(grab_in), .chop_in(chop_in), .held_out(held_out), .wr_en_out(wr_en_out),
    .wr_x_out(wr_x_out), .wr_y_out(wr_y_out), .wr_obj_out(wr_obj_out),
    .chop_progress_out(chop_progress_out), .chopping_out(chopping_out),
    .chop_done_out(chop_done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge; inputs change there too.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic face(input logic [3:0] obj, input logic [3:0] x, input logic [2:0] y);
    object_in = obj;
    front_x_in = x;
    front_y_in = y;
    front_valid_in = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got=0 expected=1");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n_in = 1'b0; grab_in = 1'b1; chop_in = 1'b0;
    face(4'd2, 4'd5, 3'd3);

    // Reset with grab held, then release with grab still held
    tick(); tick();
    check_eq("rst_held", held_out, 0);
    check_eq("rst_wr_en", wr_en_out, 0);
    check_eq("rst_wr_x", wr_x_out, 0);
    check_eq("rst_wr_obj", wr_obj_out, 0);
    check_eq("rst_progress", chop_progress_out, 0);
    check_eq("rst_chopping", chopping_out, 0);
    check_eq("rst_done", chop_done_out, 0);
    rst_n_in = 1'b1;
    tick();
    check_eq("rel_wr_en0", wr_en_out, 0);
    tick();
    check_eq("rel_wr_en1", wr_en_out, 0);
    check_eq("rel_held", held_out, 0);
    grab_in = 1'b0;
    tick();

    // Pick up onion at (5,3)
    grab_in = 1'b1;
    tick();
    check_eq("pick_wr_en", wr_en_out, 1);
    check_eq("pick_wr_x", wr_x_out, 5);
    check_eq("pick_wr_y", wr_y_out, 3);
    check_eq("pick_wr_obj", wr_obj_out, 0);
    check_eq("pick_held", held_out, 2);
    grab_in = 1'b0; object_in = 4'd0;
    tick();
    check_eq("pick_settle_wr_en", wr_en_out, 0);
    grab_in = 1'b1;
    tick();
    check_eq("pick_early_grab", wr_en_out, 0);
    tick();
    check_eq("pick_no_edge", wr_en_out, 0);
    check_eq("pick_held_keep", held_out, 2);
    grab_in = 1'b0;
    tick();

    // Put down at (6,3)
    face(4'd0, 4'd6, 3'd3);
    grab_in = 1'b1;
    tick();
    check_eq("put_wr_en", wr_en_out, 1);
    check_eq("put_wr_x", wr_x_out, 6);
    check_eq("put_wr_y", wr_y_out, 3);
    check_eq("put_wr_obj", wr_obj_out, 2);
    check_eq("put_held", held_out, 0);
    grab_in = 1'b0; object_in = 4'd2;
    tick(); tick();
    grab_in = 1'b1;
    tick();
    check_eq("repick_held", held_out, 2);
    grab_in = 1'b0; object_in = 4'd0;
    tick(); tick();

    // Putting down onto a wall is refused
    object_in = 4'd1;
    grab_in = 1'b1;
    tick();
    check_eq("wall_wr_en", wr_en_out, 0);
    check_eq("wall_held", held_out, 2);
    check_eq("wall_wr_x_hold", wr_x_out, 6);
    check_eq("wall_wr_obj_hold", wr_obj_out, 0);
    grab_in = 1'b0;
    tick();
    object_in = 4'd0;
    grab_in = 1'b1;
    tick();
    check_eq("drop_held", held_out, 0);
    grab_in = 1'b0;
    tick(); tick();

    // Full chop of tomato at (2,1)
    face(4'd4, 4'd2, 3'd1);
    chop_in = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("chop_prog%0d", i), chop_progress_out, i);
      check_eq($sformatf("chop_busy%0d", i), chopping_out, 1);
      check_eq($sformatf("chop_nodone%0d", i), chop_done_out, 0);
      check_eq($sformatf("chop_nowr%0d", i), wr_en_out, 0);
      tick();
    end
    check_eq("chop_wr_en", wr_en_out, 1);
    check_eq("chop_wr_x", wr_x_out, 2);
    check_eq("chop_wr_y", wr_y_out, 1);
    check_eq("chop_wr_obj", wr_obj_out, 5);
    check_eq("chop_done", chop_done_out, 1);
    check_eq("chop_clear", chop_progress_out, 0);
    check_eq("chop_held", held_out, 0);
    object_in = 4'd5;
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wr_en_out || chopping_out || chop_done_out) writes++;
    end
    check_eq("chop_no_restart", writes, 0);
    chop_in = 1'b0;
    tick();

    // Aborted chops: release chop, move cursor, leave grid
    for (int v = 0; v < 3; v++) begin
      face(4'd4, 4'd2, 3'd1);
      chop_in = 1'b1;
      tick();
      tick(); tick(); tick(); tick();
      check_eq($sformatf("abort%0d_prog4", v), chop_progress_out, 4);
      case (v)
        0: chop_in = 1'b0;
        1: front_x_in = 4'd3;
        default: front_valid_in = 1'b0;
      endcase
      tick();
      check_eq($sformatf("abort%0d_wr_en", v), wr_en_out, 0);
      check_eq($sformatf("abort%0d_done", v), chop_done_out, 0);
      check_eq($sformatf("abort%0d_prog", v), chop_progress_out, 0);
      check_eq($sformatf("abort%0d_busy", v), chopping_out, 0);
      chop_in = 1'b0;
      tick();
      check_eq($sformatf("abort%0d_idle", v), wr_en_out | chopping_out, 0);
    end

    // Grab and chop together: grab wins
    face(4'd2, 4'd5, 3'd3);
    grab_in = 1'b1; chop_in = 1'b1;
    tick();
    check_eq("both_wr_en", wr_en_out, 1);
    check_eq("both_wr_obj", wr_obj_out, 0);
    check_eq("both_held", held_out, 2);
    check_eq("both_busy", chopping_out, 0);
    grab_in = 1'b0; object_in = 4'd0;
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (chopping_out) writes++;
    end
    check_eq("both_never_chop", writes, 0);
    chop_in = 1'b0;
    grab_in = 1'b1;
    tick();
    check_eq("both_drop", held_out, 0);
    grab_in = 1'b0;
    tick(); tick();

    // Reset asserted mid-chop
    face(4'd2, 4'd7, 3'd4);
    chop_in = 1'b1;
    tick(); tick(); tick();
    check_eq("rchop_busy", chopping_out, 1);
    rst_n_in = 1'b0;
    tick();
    check_eq("rchop_wr_en", wr_en_out, 0);
    check_eq("rchop_busy_off", chopping_out, 0);
    check_eq("rchop_prog", chop_progress_out, 0);
    check_eq("rchop_wr_x", wr_x_out, 0);
    check_eq("rchop_wr_obj", wr_obj_out, 0);
    check_eq("rchop_held", held_out, 0);
    rst_n_in = 1'b1; chop_in = 1'b0;
    tick();
    check_eq("rchop_after", wr_en_out | chopping_out | chop_done_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
